// File: rtl/elevator_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | elevator_sequencer                                                         |
// | Latches floor calls, selects travel direction and sequences the car        |
// | through run / arrive / door-open / door-close cycles.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module elevator_sequencer #(
    parameter int NFLOOR  = 4,
    parameter int FLOOR_W = 2,
    parameter int HOME    = 0
) (
    input  logic               CP,
    input  logic               rst,
    input  logic [NFLOOR-1:0]  call,
    input  logic               endRun,
    input  logic               endOpen,
    output logic               mv2nxt,
    output logic               opendoor,
    output logic [FLOOR_W-1:0] floor,
    output logic               dir,
    output logic [NFLOOR-1:0]  pending,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_ARRIVE = 3'd2,
        S_OPEN   = 3'd3,
        S_CLOSE  = 3'd4
    } state_t;

    localparam logic [FLOOR_W-1:0] c_TOP  = FLOOR_W'(NFLOOR - 1);
    localparam logic [FLOOR_W-1:0] c_HOME = FLOOR_W'(HOME);
    localparam logic [FLOOR_W-1:0] c_ONE  = FLOOR_W'(1);

    state_t               r_state;
    logic [FLOOR_W-1:0]   r_floor;
    logic                 r_dir;
    logic [NFLOOR-1:0]    r_pending;
    logic                 r_mv2nxt;
    logic                 r_opendoor;
    logic                 r_busy;

    logic                 w_above;
    logic                 w_below;
    logic                 w_here;
    logic                 w_dir_fwd;
    logic                 w_dir_rev;
    logic                 w_enter_open;
    logic                 w_dir_nxt;
    logic [NFLOOR-1:0]    w_pending_nxt;

    always_comb begin
        w_above = 1'b0;
        w_below = 1'b0;
        for (int i = 0; i < NFLOOR; i++) begin
            if (i > int'(r_floor)) w_above = w_above | r_pending[i];
            if (i < int'(r_floor)) w_below = w_below | r_pending[i];
        end
    end

    assign w_here       = r_pending[r_floor];
    assign w_dir_fwd    = r_dir ? w_above : w_below;
    assign w_dir_rev    = r_dir ? w_below : w_above;
    assign w_enter_open = ((r_state == S_IDLE) || (r_state == S_ARRIVE)) && w_here;

    // Reverse only when nothing is served here or ahead; end floors pin direction.
    always_comb begin
        w_dir_nxt = r_dir;
        if (!w_here && !w_dir_fwd && w_dir_rev) w_dir_nxt = ~r_dir;
        if (r_floor == c_TOP)  w_dir_nxt = 1'b0;
        if (r_floor == '0)     w_dir_nxt = 1'b1;
    end

    // A call for the floor whose door is open (or opening) is already served.
    always_comb begin
        w_pending_nxt = r_pending | call;
        if ((r_state == S_OPEN) || w_enter_open) w_pending_nxt[r_floor] = 1'b0;
    end

    always_ff @(posedge CP or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_floor    <= c_HOME;
            r_dir      <= 1'b1;
            r_pending  <= '0;
            r_mv2nxt   <= 1'b0;
            r_opendoor <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            unique case (r_state)
                S_IDLE: begin
                    r_dir <= w_dir_nxt;
                    if (w_here) begin
                        r_state    <= S_OPEN;
                        r_opendoor <= 1'b1;
                        r_busy     <= 1'b1;
                    end else if (w_dir_fwd) begin
                        r_state  <= S_RUN;
                        r_mv2nxt <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (endRun) begin
                        r_floor  <= r_dir ? (r_floor + c_ONE) : (r_floor - c_ONE);
                        r_state  <= S_ARRIVE;
                        r_mv2nxt <= 1'b0;
                    end
                end
                S_ARRIVE: begin
                    r_dir <= w_dir_nxt;
                    if (w_here) begin
                        r_state    <= S_OPEN;
                        r_opendoor <= 1'b1;
                    end else if (w_dir_fwd || w_dir_rev) begin
                        r_state  <= S_RUN;
                        r_mv2nxt <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_OPEN: begin
                    if (endOpen) begin
                        r_state    <= S_CLOSE;
                        r_opendoor <= 1'b0;
                    end
                end
                S_CLOSE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_mv2nxt   <= 1'b0;
                    r_opendoor <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign mv2nxt   = r_mv2nxt;
    assign opendoor = r_opendoor;
    assign floor    = r_floor;
    assign dir      = r_dir;
    assign pending  = r_pending;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_elevator_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_elevator_sequencer                                                      |
// | Directed and randomized stimulus against a behavioural elevator model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_elevator_sequencer;

    localparam int NF = 4;
    localparam int FW = 2;

    logic          CP = 1'b0;
    logic          rst;
    logic [NF-1:0] call;
    logic          endRun;
    logic          endOpen;
    logic          mv2nxt;
    logic          opendoor;
    logic [FW-1:0] floor;
    logic          dir;
    logic [NF-1:0] pending;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef enum int {PH_IDLE, PH_RUN, PH_ARRIVE, PH_OPEN, PH_CLOSE} phase_t;
    phase_t        m_ph;
    int            m_floor;
    bit            m_dir;
    logic [NF-1:0] m_pend;
    int            prev_floor;

    elevator_sequencer #(.NFLOOR(NF), .FLOOR_W(FW), .HOME(0)) dut (
        .CP       (CP),
        .rst      (rst),
        .call     (call),
        .endRun   (endRun),
        .endOpen  (endOpen),
        .mv2nxt   (mv2nxt),
        .opendoor (opendoor),
        .floor    (floor),
        .dir      (dir),
        .pending  (pending),
        .busy     (busy)
    );

    always #5 CP = ~CP;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph       = PH_IDLE;
        m_floor    = 0;
        m_dir      = 1'b1;
        m_pend     = '0;
        prev_floor = 0;
    endtask

    // One clock edge of the car's behaviour, applied to the inputs now on the pins.
    task automatic model_step();
        int     n_above, n_below;
        bit     here, fwd, rev;
        phase_t nph;
        int     nfloor;
        bit     ndir;
        n_above = 0;
        n_below = 0;
        for (int j = 0; j < NF; j++) begin
            if (m_pend[j] && j > m_floor) n_above++;
            if (m_pend[j] && j < m_floor) n_below++;
        end
        here   = m_pend[m_floor];
        fwd    = m_dir ? (n_above > 0) : (n_below > 0);
        rev    = m_dir ? (n_below > 0) : (n_above > 0);
        nph    = m_ph;
        nfloor = m_floor;
        ndir   = m_dir;
        case (m_ph)
            PH_IDLE: begin
                if (here) nph = PH_OPEN;
                else if (fwd) nph = PH_RUN;
                else if (rev) ndir = !m_dir;
            end
            PH_RUN: begin
                if (endRun) begin
                    nfloor = m_dir ? m_floor + 1 : m_floor - 1;
                    nph    = PH_ARRIVE;
                end
            end
            PH_ARRIVE: begin
                if (here) nph = PH_OPEN;
                else if (fwd) nph = PH_RUN;
                else if (rev) begin
                    ndir = !m_dir;
                    nph  = PH_RUN;
                end else nph = PH_IDLE;
            end
            PH_OPEN:  if (endOpen) nph = PH_CLOSE;
            default:  nph = PH_IDLE;
        endcase
        if (m_ph == PH_IDLE || m_ph == PH_ARRIVE) begin
            if (m_floor == NF - 1) ndir = 1'b0;
            if (m_floor == 0) ndir = 1'b1;
        end
        m_pend = m_pend | call;
        if (m_ph == PH_OPEN || nph == PH_OPEN) m_pend[m_floor] = 1'b0;
        m_ph    = nph;
        m_floor = nfloor;
        m_dir   = ndir;
    endtask

    task automatic compare_all();
        int step;
        check("mv2nxt",   32'(mv2nxt),   32'(m_ph == PH_RUN));
        check("opendoor", 32'(opendoor), 32'(m_ph == PH_OPEN));
        check("busy",     32'(busy),     32'(m_ph != PH_IDLE));
        check("dir",      32'(dir),      32'(m_dir));
        check("floor",    32'(floor),    32'(m_floor));
        check("pending",  32'(pending),  32'(m_pend));
        step = int'(floor) - prev_floor;
        check("floor_step", 32'(step >= -1 && step <= 1), 32'(1));
        prev_floor = int'(floor);
    endtask

    task automatic tick(input logic [NF-1:0] c, input logic er, input logic eo);
        call    = c;
        endRun  = er;
        endOpen = eo;
        model_step();
        @(posedge CP);
        #1;
        compare_all();
    endtask

    // Reset lands between edges so its effect must be immediate.
    task automatic rst_assert();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
    endtask

    task automatic rst_release();
        @(posedge CP);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        call    = '0;
        endRun  = 1'b0;
        endOpen = 1'b0;
        model_reset();
        repeat (2) @(posedge CP);
        #1;
        compare_all();
        check("rst_floor", 32'(floor), 32'(0));
        check("rst_dir",   32'(dir),   32'(1));
        rst = 1'b0;

        // Call to floor 2 from floor 0
        tick(4'b0100, 1'b0, 1'b0);
        check("t1_pend", 32'(pending), 32'(4'b0100));
        check("t1_mv_wait", 32'(mv2nxt), 32'(0));
        tick(4'b0000, 1'b0, 1'b0);
        check("t1_mv_rise", 32'(mv2nxt), 32'(1));
        tick(4'b0000, 1'b1, 1'b0);
        check("t1_floor1", 32'(floor), 32'(1));
        check("t1_mv_gap", 32'(mv2nxt), 32'(0));
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        check("t1_open",  32'(opendoor), 32'(1));
        check("t1_floor", 32'(floor),    32'(2));
        check("t1_pend0", 32'(pending),  32'(0));
        check("t1_dir",   32'(dir),      32'(1));
        tick(4'b0000, 1'b0, 1'b1);
        tick(4'b0000, 1'b0, 1'b0);

        // Up to the top floor; call[3] held while the door is open there
        tick(4'b1000, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        check("t6_open", 32'(opendoor), 32'(1));
        check("t6_dir",  32'(dir),      32'(0));
        repeat (5) tick(4'b1000, 1'b0, 1'b0);
        check("t6_pend3", 32'(pending[3]), 32'(0));
        tick(4'b0000, 1'b0, 1'b1);
        tick(4'b0000, 1'b0, 1'b0);
        repeat (3) tick(4'b0000, 1'b0, 1'b0);
        check("t6_noreopen", 32'(opendoor), 32'(0));
        check("t6_idle",     32'(busy),     32'(0));

        // Reset while running at floor 2 with a call to floor 3 outstanding
        rst_assert();
        rst_release();
        tick(4'b1000, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        check("t5_run",    32'(mv2nxt), 32'(1));
        check("t5_floor2", 32'(floor),  32'(2));
        rst_assert();
        check("t5_mv",    32'(mv2nxt),  32'(0));
        check("t5_floor", 32'(floor),   32'(0));
        check("t5_pend",  32'(pending), 32'(0));
        rst_release();

        // Door cycle at the current floor from IDLE at floor 1
        tick(4'b0010, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b1);
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0010, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        check("t2_open",  32'(opendoor), 32'(1));
        check("t2_floor", 32'(floor),    32'(1));
        tick(4'b0000, 1'b0, 1'b1);
        tick(4'b0000, 1'b0, 1'b0);
        check("t2_busy", 32'(busy), 32'(0));

        // Up-sweep with calls 0,2,3, then back down; timers held done throughout
        tick(4'b1101, 1'b0, 1'b0);
        repeat (50) tick(4'b0000, 1'b1, 1'b1);
        check("t3_floor", 32'(floor),   32'(0));
        check("t3_pend",  32'(pending), 32'(0));
        check("t4_busy",  32'(busy),    32'(0));

        for (int k = 0; k < 4000; k++) begin
            logic [NF-1:0] c;
            c = ($urandom_range(0, 5) == 0) ? NF'($urandom_range(1, 15)) : '0;
            if ($urandom_range(0, 599) == 0) begin
                rst_assert();
                rst_release();
            end
            tick(c, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
